// File: rtl/fmul_if.sv
// Operand/result channel of the pipelined FP multiplier.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; the sender holds
//   its payload stable and keeps valid asserted until then, and ready may depend on the receiver's state.
interface fmul_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 5
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     s;
   logic [W-1:0]     t;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     d;
   logic [TAG_W-1:0] out_tag;
   logic             overflow;
   logic             underflow;

   modport master (
      output in_valid, s, t, in_tag, out_ready,
      input  in_ready, out_valid, d, out_tag, overflow, underflow
   );

   modport slave (
      input  in_valid, s, t, in_tag, out_ready,
      output in_ready, out_valid, d, out_tag, overflow, underflow
   );
endinterface

// File: rtl/fmul_pipe.sv
// Fully pipelined IEEE-754 multiplier, flush-to-zero, round-to-nearest-even, with tag and stall.
// The whole pipe advances together; a stalled output freezes every stage.
module fmul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int LAT   = 3,
   parameter int TAG_W = 5
) (
   input logic   clk,
   input logic   rst,
   fmul_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 1;
   localparam int PW = 2 * MW;
   localparam int P  = (LAT > 3) ? LAT - 2 : 1;
   localparam logic [EXP_W+1:0] BIAS  = (EXP_W+2)'(2**(EXP_W-1) - 1);
   localparam logic [EXP_W+1:0] E_MAX = (EXP_W+2)'(2**EXP_W - 1);
   localparam logic [W-1:0] QBIT = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic [EXP_W+1:0] exp;
      logic [MW-1:0]    ma;
      logic [MW-1:0]    mb;
      logic             spec;
      logic [W-1:0]     sval;
   } op_t;

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic [EXP_W+1:0] exp;
      logic [PW-1:0]    prod;
      logic             spec;
      logic [W-1:0]     sval;
   } mid_t;

   logic en;
   assign en           = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = en;

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   op_t  op_in, op_q, mul_src;
   mid_t mid_in;
   mid_t mid_q [P];

   // Unpack and classify; exponent field 0 covers both zero and subnormal (flushed).
   always_comb begin
      ea     = bus.s[W-2:MAN_W];
      eb     = bus.t[W-2:MAN_W];
      fa     = bus.s[MAN_W-1:0];
      fb     = bus.t[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (&ea) & (fa == '0);
      b_inf  = (&eb) & (fb == '0);
      a_nan  = (&ea) & (fa != '0);
      b_nan  = (&eb) & (fb != '0);
      op_in      = '0;
      op_in.v    = bus.in_valid;
      op_in.tag  = bus.in_tag;
      op_in.sign = bus.s[W-1] ^ bus.t[W-1];
      op_in.exp  = {2'b00, ea} + {2'b00, eb} - BIAS;
      op_in.ma   = {1'b1, fa};
      op_in.mb   = {1'b1, fb};
      op_in.spec = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
      if (a_nan)
         op_in.sval = bus.s | QBIT;
      else if (b_nan)
         op_in.sval = bus.t | QBIT;
      else if ((a_inf & b_zero) | (b_inf & a_zero))
         op_in.sval = QNAN;
      else if (a_inf | b_inf)
         op_in.sval = {op_in.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         op_in.sval = {op_in.sign, {(W-1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst)
         op_q <= '0;
      else if (en)
         op_q <= op_in;
   end

   // With LAT=2 the multiply sits directly behind the input, skipping the operand register.
   assign mul_src = (LAT == 2) ? op_in : op_q;

   always_comb begin
      mid_in      = '0;
      mid_in.v    = mul_src.v;
      mid_in.tag  = mul_src.tag;
      mid_in.sign = mul_src.sign;
      mid_in.exp  = mul_src.exp;
      mid_in.prod = {{MW{1'b0}}, mul_src.ma} * {{MW{1'b0}}, mul_src.mb};
      mid_in.spec = mul_src.spec;
      mid_in.sval = mul_src.sval;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < P; i++) mid_q[i] <= '0;
      end else if (en) begin
         mid_q[0] <= mid_in;
         for (int i = 1; i < P; i++) mid_q[i] <= mid_q[i-1];
      end
   end

   mid_t             m;
   logic             msb, guard, sticky, rnd, ovf_c, unf_c;
   logic [PW-2:0]    nprod;
   logic [MAN_W-1:0] frac;
   logic [MAN_W:0]   frac_r;
   logic [EXP_W+1:0] res_e;
   logic [W-1:0]     res;

   // Normalise to 1.x, round on guard/sticky; a carry out of the fraction bumps the exponent.
   always_comb begin
      m      = mid_q[P-1];
      msb    = m.prod[PW-1];
      nprod  = msb ? m.prod[PW-2:0] : {m.prod[PW-3:0], 1'b0};
      frac   = nprod[PW-2 -: MAN_W];
      guard  = nprod[PW-2-MAN_W];
      sticky = |nprod[PW-3-MAN_W:0];
      rnd    = guard & (sticky | frac[0]);
      frac_r = {1'b0, frac} + (MAN_W+1)'(rnd);
      res_e  = m.exp + (EXP_W+2)'(msb) + (EXP_W+2)'(frac_r[MAN_W]);
      ovf_c  = 1'b0;
      unf_c  = 1'b0;
      if (m.spec) begin
         res = m.sval;
      end else if ($signed(res_e) >= $signed(E_MAX)) begin
         res   = {m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         ovf_c = 1'b1;
      end else if (res_e[EXP_W+1] | (res_e == '0)) begin
         res   = {m.sign, {(W-1){1'b0}}};
         unf_c = 1'b1;
      end else begin
         res = {m.sign, res_e[EXP_W-1:0], frac_r[MAN_W-1:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.d         <= '0;
         bus.out_tag   <= '0;
         bus.overflow  <= 1'b0;
         bus.underflow <= 1'b0;
      end else if (en) begin
         bus.out_valid <= m.v;
         bus.d         <= res;
         bus.out_tag   <= m.tag;
         bus.overflow  <= ovf_c;
         bus.underflow <= unf_c;
      end
   end
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: vector table with hand-computed products, then stall and
// mid-flight reset sequences.
module tb_fmul_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int LAT   = 3;
   localparam int TAG_W = 5;
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int NV    = 21;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fmul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

   fmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [W-1:0]     s;
      logic [W-1:0]     t;
      logic [TAG_W-1:0] tag;
      logic [W-1:0]     d;
      logic             ovf;
      logic             unf;
   } vec_t;

   vec_t vecs [NV];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [W+TAG_W+1:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input int i, input logic [W-1:0] s, input logic [W-1:0] t,
                                   input logic [W-1:0] d, input logic ovf, input logic unf);
      vecs[i].s   = s;
      vecs[i].t   = t;
      vecs[i].tag = TAG_W'(i);
      vecs[i].d   = d;
      vecs[i].ovf = ovf;
      vecs[i].unf = unf;
   endfunction

   // driver: present one op at the drive point (posedge + 1)
   task automatic drive_op(input logic [W-1:0] s, input logic [W-1:0] t, input logic [TAG_W-1:0] tag);
      bus.in_valid = 1'b1;
      bus.s        = s;
      bus.t        = t;
      bus.in_tag   = tag;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sent, got, cyc, stalls, extra;
      logic held;
      logic [W+TAG_W+1:0] snap;

      add_vec(0,  32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
      vecs[0].tag = 5'd5;
      add_vec(1,  32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0);
      add_vec(2,  32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
      add_vec(3,  32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
      add_vec(4,  32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);
      add_vec(5,  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);
      add_vec(6,  32'hFFA00000, 32'h3F800000, 32'hFFE00000, 1'b0, 1'b0);
      add_vec(7,  32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0);
      add_vec(8,  32'h3F800000, 32'h7FA00000, 32'h7FE00000, 1'b0, 1'b0);
      add_vec(9,  32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0);
      add_vec(10, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0);
      add_vec(11, 32'h80400000, 32'h40000000, 32'h80000000, 1'b0, 1'b0);
      add_vec(12, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);
      add_vec(13, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 1'b0, 1'b0);
      add_vec(14, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
      add_vec(15, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0);
      add_vec(16, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0);
      add_vec(17, 32'h80800000, 32'h3F000000, 32'h80000000, 1'b0, 1'b1);
      add_vec(18, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
      add_vec(19, 32'h7F800001, 32'h00000000, 32'h7FC00001, 1'b0, 1'b0);
      add_vec(20, 32'h7F400000, 32'h3FC00000, 32'h7F800000, 1'b1, 1'b0);

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.s         = '0;
      bus.t         = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      @(posedge clk); #3;
      check("rst out_valid", bus.out_valid, 0);
      check("rst d", bus.d, 0);
      check("rst out_tag", bus.out_tag, 0);
      check("rst flags", {bus.overflow, bus.underflow}, 0);
      rst = 1'b0;
      @(posedge clk); #3;
      check("in_ready after rst", bus.in_ready, 1);

      // table: one op at a time, latency and result per vector
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive_op(vecs[i].s, vecs[i].t, vecs[i].tag);
         #2;
         check($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         #2;
         lat = 1;
         while (!bus.out_valid && lat < LAT + 8) begin
            @(posedge clk); #3;
            lat++;
         end
         check($sformatf("vec%0d latency", i), lat, LAT);
         check($sformatf("vec%0d d", i), bus.d, vecs[i].d);
         check($sformatf("vec%0d tag", i), bus.out_tag, vecs[i].tag);
         check($sformatf("vec%0d ovf/unf", i), {bus.overflow, bus.underflow}, {vecs[i].ovf, vecs[i].unf});
      end

      // back-to-back stream with a 3-cycle consumer stall
      @(posedge clk); #1;
      sent = 0; got = 0; cyc = 0; stalls = 0; held = 1'b0; snap = '0;
      exp_q.delete();
      while (got < 6 && cyc < 60) begin
         bus.out_ready = !(cyc >= 5 && cyc < 8);
         if (sent < 6) drive_op(vecs[sent+1].s, vecs[sent+1].t, TAG_W'(sent));
         else bus.in_valid = 1'b0;
         #2;
         check("stall in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         if (held) begin
            check("stall out_valid held", bus.out_valid, 1);
            check("stall outputs held", {bus.d, bus.out_tag, bus.overflow, bus.underflow}, snap);
         end
         held = 1'b0;
         if (bus.out_valid && !bus.out_ready) begin
            held = 1'b1;
            stalls++;
            snap = {bus.d, bus.out_tag, bus.overflow, bus.underflow};
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({vecs[sent+1].d, TAG_W'(sent), vecs[sent+1].ovf, vecs[sent+1].unf});
            sent++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("stream unexpected output", 1, 0);
            end else begin
               check($sformatf("stream result %0d", got), {bus.d, bus.out_tag, bus.overflow, bus.underflow},
                     exp_q.pop_front());
            end
            got++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check("stream retired count", got, 6);
      check("stream stall cycles", stalls, 3);
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #3;
         if (bus.out_valid) extra++;
      end
      check("stream no duplicates", extra, 0);

      // reset with three ops in flight and the consumer stalled
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      sent = 0; cyc = 0;
      while (sent < 3 && cyc < 20) begin
         drive_op(vecs[12+sent].s, vecs[12+sent].t, TAG_W'(20 + sent));
         #2;
         if (bus.in_valid && bus.in_ready) sent++;
         cyc++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      #2;
      check("flight ops accepted", sent, 3);
      check("flight out_valid stalled", bus.out_valid, 1);
      check("flight in_ready stalled", bus.in_ready, 0);
      rst = 1'b1;
      @(posedge clk); #3;
      check("mid rst out_valid", bus.out_valid, 0);
      check("mid rst d/tag", {bus.d, bus.out_tag}, 0);
      rst = 1'b0;
      @(posedge clk); #3;
      check("in_ready after mid rst", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      extra = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #3;
         if (bus.out_valid) extra++;
      end
      check("flushed ops never emerge", extra, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
